div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Multi-cycle radix-2 restoring divider for DIV/DIVU. Responds to execute-stage requests;
//   EX stalls the pipeline until ready_o, then writes result_o to HI/LO (HI=remainder, LO=quotient).
//   One division in flight at a time. Annul_i squashes it when the instruction is flushed.
// PARAMETERS
//   DATA_W    32   operand width; result_o is 2*DATA_W. Only 32 is supported with HI/LO.
//   CNT_W     6    iteration counter width; must hold the value DATA_W.
// PORTS
//   clk            in   1         clock, rising edge
//   rst            in   1         reset, synchronous, active-high
//   signed_div_i   in   1         1 = DIV (signed), 0 = DIVU; sampled at acceptance
//   opdata1_i      in   DATA_W    dividend; sampled at acceptance
//   opdata2_i      in   DATA_W    divisor; sampled at acceptance
//   start_i        in   1         request, held high by EX until it has consumed the result
//   annul_i        in   1         cancel the current or requested division
//   result_o       out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1
//   ready_o        out  1         result valid
// BEHAVIOUR
//   Reset: state=FREE, cnt=0, result_o=0, ready_o=0. rst mid-operation aborts immediately.
//   States:
//     FREE  : start_i=1 & annul_i=0 -> latch operands.
//             If divisor==0 -> BYZERO, else -> ON with cnt=0. Otherwise stay.
//     BYZERO: -> END with result 0 (both halves 0). Decided value; no trap.
//     ON    : annul_i=1 -> FREE, result discarded. Else one restoring step per cycle:
//             rem' = {rem,q_msb} - divisor; if no borrow take the difference and shift in 1,
//             else keep and shift in 0.
//             At cnt==DATA_W-1 the final step also applies the sign fix-up, then -> END; else cnt++.
//     END   : ready_o=1, result_o held stable. start_i=0 -> FREE (ready_o=0, result_o=0 next cycle).
//             annul_i=1 -> FREE.
//   Latency, counted from the acceptance edge e0:
//     nonzero divisor: ready_o high after edge e32 (32 ON cycles).
//     zero divisor   : ready_o high after edge e2.
//   Signed: operate on |opdata1|, |opdata2|.
//     quotient negated if operand signs differ; remainder takes the dividend's sign.
//     0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0 (wraps, no exception).
//   start_i in ON/BYZERO/END is not a new request. Back-to-back divides need start_i low >=1 cycle.
//   annul_i has priority over start_i in every state. Simultaneous start_i+annul_i in FREE -> no acceptance.
//   ready_o and result_o are registered outputs; no combinational path from inputs.
// CONFIGURATION
//   DIV_SIGNED_EN defined:
//     signed_div_i honoured as above.
//   DIV_SIGNED_EN undefined:
//     signed_div_i ignored; every division is unsigned.
//     No abs/negate logic is built; DIV decodes to the DIVU datapath.
// TESTING
//   1. DIVU 100/7, start held -> ready_o after e32, result_o=0x00000002_0000000E.
//      Drop start_i -> ready_o=0 next cycle.
//   2. DIV 0xFFFFFFF9/2 (signed -7/2) -> result_o=0xFFFFFFFF_FFFFFFFD.
//      With DIV_SIGNED_EN undefined -> 0x00000001_7FFFFFFC.
//   3. DIVU 5/0 -> ready_o after e2, result_o=0. Unit returns to FREE and accepts the next request.
//   4. DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000.
//   5. DIVU 1000/3 with annul_i pulsed at cycle e10 -> FREE at e11, ready_o never asserts.
//      The following DIVU 9/3 gives 0x00000000_00000003.
//   6. rst asserted at cycle e15 mid-division -> next cycle FREE, ready_o=0, result_o=0.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
// Handshake: EX raises start_i with operands and holds it; the divider raises ready_o with result_o; EX drops start_i once it has consumed the result.
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Build option DIV_SIGNED_EN: when defined, signed_div_i selects signed division; otherwise all divides are unsigned.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic                w_load;
  logic                w_step;
  logic                w_last;
  logic                w_zero_done;
  logic                w_clear;

  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_partial;
  logic [DATA_W-1:0]   w_sub;
  logic                w_ge;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quo_next;
  logic [DATA_W-1:0]   w_rem_fin;
  logic [DATA_W-1:0]   w_quo_fin;

`ifdef DIV_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg_q;
  logic r_neg_r;

  // Divide magnitudes; the signs are remembered and re-applied on the final step.
  assign w_neg_a   = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_neg_b   = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_abs_a   = w_neg_a ? ('0 - bus.opdata1_i) : bus.opdata1_i;
  assign w_abs_b   = w_neg_b ? ('0 - bus.opdata2_i) : bus.opdata2_i;
  assign w_quo_fin = r_neg_q ? ('0 - w_quo_next) : w_quo_next;
  assign w_rem_fin = r_neg_r ? ('0 - w_rem_next) : w_rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load) begin
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = bus.signed_div_i;
  assign w_abs_a         = bus.opdata1_i;
  assign w_abs_b         = bus.opdata2_i;
  assign w_quo_fin       = w_quo_next;
  assign w_rem_fin       = w_rem_next;
`endif

  // One restoring step: shift the next dividend bit into the remainder and try the subtract.
  assign w_partial  = {r_rem, r_quo[DATA_W-1]};
  assign w_ge       = (w_partial >= {1'b0, r_divisor});
  assign w_sub      = w_partial[DATA_W-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_sub : w_partial[DATA_W-1:0];
  assign w_quo_next = {r_quo[DATA_W-2:0], w_ge};
  assign w_last     = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // annul_i is checked first in every state so it always wins over start_i.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_zero_done  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          w_load       = 1'b1;
          w_state_next = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        if (bus.annul_i) begin
          w_state_next = S_FREE;
        end else begin
          w_zero_done  = 1'b1;
          w_state_next = S_END;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          w_state_next = S_FREE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_state_next = S_END;
          end
        end
      end
      S_END: begin
        if (bus.annul_i || !bus.start_i) begin
          w_clear      = 1'b1;
          w_state_next = S_FREE;
        end
      end
      default: w_state_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt     <= '0;
        r_divisor <= w_abs_b;
        r_rem     <= '0;
        r_quo     <= w_abs_a;
      end
      if (w_step) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_result <= {w_rem_fin, w_quo_fin};
          r_ready  <= 1'b1;
        end
      end
      if (w_zero_done) begin
        r_result <= '0;
      end
      // The divide-by-zero path raises ready_o one edge after entering END.
      if (r_state == S_END && !w_clear) begin
        r_ready <= 1'b1;
      end
      if (w_clear) begin
        r_result <= '0;
        r_ready  <= 1'b0;
      end
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random divisions checked against an arithmetic reference model.
module tb_div_unit;

  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  div_if #(.DATA_W(DATA_W)) dif ();

  div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif.slave),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*DATA_W-1:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain integer arithmetic on the operands
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
`endif
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // monitor: each rising ready_o must match the oldest expected result
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready <= 1'b0;
    end else begin
      if (dif.ready_o && !prev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got result 0x%0h with no request outstanding", dif.result_o);
        end else begin
          check("result", dif.result_o, exp_q.pop_front());
        end
      end
      prev_ready <= dif.ready_o;
    end
  end

  // driver: issue one division, hold start until ready, then release
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int  n;
    bit  seen;
    exp_q.push_back(exp);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    n    = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (dif.ready_o) seen = 1;
    end
    check("latency", 64'(n), (b == 32'd0) ? 64'd3 : 64'd33);
    if (seen) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(dif.ready_o), 64'd1);
      check("hold_result", dif.result_o, exp);
    end
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(dif.ready_o), 64'd0);
    check("drop_result", dif.result_o, 64'd0);
  endtask

  initial begin
    bit        any_ready;
    bit        s;
    logic [31:0] a, b;

    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(dif.ready_o), 64'd0);
    check("reset_result", dif.result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
`ifdef DIV_SIGNED_EN
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
`else
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
`endif
    run_div(1'b0, 32'd5, 32'd0, 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    run_div(1'b0, 32'd3, 32'd10, 64'h00000003_00000000);

    // annul mid-division: no result may ever appear
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    any_ready   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (dif.ready_o) any_ready = 1'b1;
    end
    check("annul_no_ready", 64'(any_ready), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // start together with annul in FREE must not be accepted
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("start_annul_ready", 64'(dif.ready_o), 64'd0);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    @(posedge clk); #1;
    run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

    // synchronous reset in the middle of a division
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd7;
    dif.start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 64'(dif.ready_o), 64'd0);
    check("midrst_result", dif.result_o, 64'd0);
    rst         = 1'b0;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    run_div(1'b0, 32'd1000, 32'd7, 64'h00000006_0000008E);

    // random divisions, occasionally with tiny or zero divisors
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 3));
        1:       b = 32'($urandom_range(0, 255));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      run_div(s, a, b, ref_div(s, a, b));
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
